// File: rtl/bus_pkg.sv
// bus_pkg -- shared constants and helpers for the bus_ram_arb slice.
//
// Contents:
//   DEF_DATA_W / DEF_ADDR_W / DEF_N_CH  default parameter values
//   MAX_CH / CH_IDX_W                   upper bound on channels and index width
//   rr_grant()       one-hot rotate-priority grant; the search starts one past 'last'
//   onehot_to_idx()  binary index of a one-hot vector
package bus_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_N_CH   = 2;

    // Channel count is bounded at 8, so helpers work on fixed 8-bit vectors.
    // Callers zero-extend their request vectors to this width.
    localparam int MAX_CH   = 8;
    localparam int CH_IDX_W = 3;

    // Round-robin pick: visit channels (last+1) mod n, (last+2) mod n, ...
    // and grant the first one that is requesting. Only the first n bits are
    // considered. The result is all-zero when no considered bit is set.
    function automatic logic [MAX_CH-1:0] rr_grant(
        input logic [MAX_CH-1:0]   req,
        input logic [CH_IDX_W-1:0] last,
        input int                  n
    );
        logic [MAX_CH-1:0]   g;
        logic                found;
        logic [CH_IDX_W-1:0] idx;
        g     = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_CH; k++) begin
            idx = CH_IDX_W'((int'(last) + k) % n);
            if ((k <= n) && !found && req[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [CH_IDX_W-1:0] onehot_to_idx(input logic [MAX_CH-1:0] oh);
        logic [CH_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) begin
                idx = idx | CH_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_ram_arb_if.sv
// bus_ram_arb_if -- channel-side bundle of the shared RAM.
//
// Signals (N_CH channels packed side by side, channel i at [i*W +: W]):
//   req    per-channel request
//   wen    per-channel write enable (1 write, 0 read)
//   addr   per-channel address, ADDR_W bits each
//   wdata  per-channel write data, DATA_W bits each
//   gnt    one-hot grant back to the channels
//   rvalid one-hot pulse, rdata valid for that channel
//   rdata  shared registered read data
//
// Handshake: req acts as valid and gnt as ready. A channel raises req with
// wen/addr/wdata and holds all four unchanged until a rising edge at which
// its gnt bit is high; that edge completes the transfer and the channel may
// change or drop its request in the following cycle. A read completed at
// edge k shows its data on rdata with rvalid[i] high from edge k to k+1.
//
// Modports: master = requesting channels, slave = bus_ram_arb.
interface bus_ram_arb_if
    import bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int N_CH   = DEF_N_CH
) ();

    logic [N_CH-1:0]        req;
    logic [N_CH-1:0]        wen;
    logic [N_CH*ADDR_W-1:0] addr;
    logic [N_CH*DATA_W-1:0] wdata;
    logic [N_CH-1:0]        gnt;
    logic [N_CH-1:0]        rvalid;
    logic [DATA_W-1:0]      rdata;

    modport master (
        output req, wen, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, wen, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter -- round-robin arbiter for up to 8 channels.
//
// Ports:
//   clk  rising-edge clock
//   clr  asynchronous active-low clear
//   req  per-channel request, N_CH bits
//   gnt  one-hot grant, combinational from req and the last-granted pointer
//
// The pointer resets to N_CH-1 so that channel 0 is searched first after
// clear. It only moves on edges where a grant is actually issued, so an
// idle cycle does not disturb fairness.
module rr_arbiter
    import bus_pkg::*;
#(
    parameter int N_CH = DEF_N_CH
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [N_CH-1:0] req,
    output logic [N_CH-1:0] gnt
);

    logic [CH_IDX_W-1:0] last_granted;
    logic [MAX_CH-1:0]   req_ext;
    logic [MAX_CH-1:0]   gnt_ext;
    logic                unused_gnt_hi;

    always_comb begin
        req_ext            = '0;
        req_ext[N_CH-1:0]  = req;
        gnt_ext            = rr_grant(req_ext, last_granted, N_CH);
        // Grants are suppressed while clear is held, independent of the clock.
        gnt                = clr ? gnt_ext[N_CH-1:0] : '0;
    end

    // Bits above N_CH are always zero; folded here so they are not left dangling.
    assign unused_gnt_hi = ^gnt_ext;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            last_granted <= CH_IDX_W'(N_CH - 1);
        end else if (|gnt) begin
            last_granted <= onehot_to_idx(gnt_ext);
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!clr) $onehot0(gnt));
    a_gnt_subset: assert property (@(posedge clk) disable iff (!clr) ((gnt & ~req) == '0));

endmodule

// File: rtl/bus_ram_arb.sv
// bus_ram_arb -- N_CH channels sharing one single-port RAM through a
// round-robin arbiter.
//
// Parameters: DATA_W word width, ADDR_W address width (2**ADDR_W words),
//             N_CH channel count (1..8).
// Ports:
//   clk  rising-edge clock
//   clr  asynchronous active-low clear: wipes the RAM, rdata, rvalid and
//        the arbiter pointer, and forces gnt low
//   bus  slave side of bus_ram_arb_if (req/wen/addr/wdata in, gnt/rvalid/rdata out)
//
// One transfer completes per edge: the granted channel either writes its
// word or loads rdata from the addressed word. The RAM is built from
// resettable registers so that clear really leaves every word at zero.
module bus_ram_arb
    import bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int N_CH   = DEF_N_CH
) (
    input  logic          clk,
    input  logic          clr,
    bus_ram_arb_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [N_CH-1:0]   gnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [N_CH-1:0]   rvalid_q;

    // Selected channel's request fields.
    logic              sel_any;
    logic              sel_wen;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .clk (clk),
        .clr (clr),
        .req (bus.req),
        .gnt (gnt)
    );

    // gnt is one-hot, so OR-ing the granted lanes is a plain mux.
    always_comb begin
        sel_any   = |gnt;
        sel_wen   = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt[i]) begin
                sel_wen   = sel_wen   | bus.wen[i];
                sel_addr  = sel_addr  | bus.addr[i*ADDR_W +: ADDR_W];
                sel_wdata = sel_wdata | bus.wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int d = 0; d < DEPTH; d++) begin
                mem[d] <= '0;
            end
        end else if (sel_any && sel_wen) begin
            mem[sel_addr] <= sel_wdata;
        end
    end

    // rvalid mirrors the grant of a completed read for exactly one cycle;
    // rdata is only reloaded by a read, so it holds across writes and idles.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            if (sel_any && !sel_wen) begin
                rvalid_q <= gnt;
                rdata_q  <= mem[sel_addr];
            end else begin
                rvalid_q <= '0;
            end
        end
    end

    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;

endmodule

// File: doc/bus_ram_arb.md
BUS_RAM_ARB -- requirements
Module: bus_ram_arb

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set the data word width in bits.
REQ-002 Parameter ADDR_W, default 4, SHALL set the address width; depth SHALL be 2**ADDR_W words.
REQ-003 Parameter N_CH, default 2, range 1..8, SHALL set the number of requesting channels.
REQ-004 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-005 clr  in  1  asynchronous, active-low clear.
REQ-006 req  in  N_CH  per-channel access request.
REQ-007 wen  in  N_CH  per-channel write enable: 1 = write, 0 = read; sampled with req.
REQ-008 addr  in  N_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 wdata  in  N_CH*DATA_W  per-channel write data, packed the same way.
REQ-010 gnt  out  N_CH  one-hot grant, combinational from req and arbiter state.
REQ-011 rvalid  out  N_CH  one-hot pulse marking rdata as valid for that channel.
REQ-012 rdata  out  DATA_W  registered read data, shared by all channels.

Function
REQ-013 gnt SHALL have at most one bit set, and SHALL be all-zero when req is all-zero.
REQ-014 Arbitration SHALL be round-robin: search starts at channel (last_granted+1) mod N_CH, and the first requesting channel wins.
REQ-015 last_granted SHALL update at a clock edge only when some gnt bit is set.
REQ-016 Handshake: a channel SHALL hold req, wen, addr and wdata stable until the edge where its gnt is high; the transfer completes at that edge.
REQ-017 Granted write: mem[addr_i] <= wdata_i at the edge; rvalid SHALL stay low for that channel.
REQ-018 Granted read: rdata <= mem[addr_i] at the edge, and rvalid[i] SHALL be high for exactly the following cycle (1-cycle latency).
REQ-019 Read data SHALL reflect all writes completed at earlier edges; a write at edge k SHALL be visible to a read granted at edge k+1.
REQ-020 When no read completes at an edge, rvalid SHALL go to 0 and rdata SHALL hold its last value.
REQ-021 Ungranted requesters SHALL be stalled with no side effects; the same channel is never starved for more than N_CH-1 grants.
REQ-022 With N_CH=1, gnt SHALL equal req.
REQ-023 Addresses SHALL wrap naturally within ADDR_W bits; no out-of-range case exists.

Reset
REQ-024 While clr=0: every memory word = 0, rdata = 0, rvalid = 0, last_granted = N_CH-1 (channel 0 has first priority), and gnt = 0.
REQ-025 Assertion mid-transfer SHALL abort the transfer: no write occurs and a pending rvalid is dropped.
REQ-026 The first edge after clr rises SHALL be a normal arbitration edge.

Structure
REQ-027 Package bus_pkg SHALL hold the default DATA_W/ADDR_W/N_CH constants and a function that returns a one-hot rotate-priority grant.
REQ-028 The arbiter SHALL be the sub-module rr_arbiter (params N_CH; ports clk, clr, req, gnt); the memory and read register SHALL stay in bus_ram_arb.

Verification
REQ-029 After reset, ch0 writes addr=1 data=1; ch0 then reads addr=1 -> rvalid[0] high one cycle later with rdata=1.
REQ-030 ch0 writes addr=0 data=15 and reads addr=0 -> rdata=15; a subsequent read of addr=1 -> rdata=1.
REQ-031 ch0 and ch1 both request continuously from reset -> gnt alternates 01,10,01,10 (bits listed ch1,ch0).
REQ-032 ch1 writes addr=3 data=9 at edge k; ch0 reads addr=3 granted at edge k+1 -> rdata=9 with rvalid[0] only.
REQ-033 clr pulsed low while ch0 holds a granted read -> rvalid=0, rdata=0, and all addresses read back 0 after release.
REQ-034 DATA_W=8, ADDR_W=6, N_CH=4 with all channels requesting -> grant order 0,1,2,3,0, and a write of 0xA5 to addr 63 reads back 0xA5.
